// File: rtl/armv8_pkg.sv
// Shared widths, constants and types for the instruction fetch path.
package armv8_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue: circular buffer of {instr, pc} entries with a
// synchronous clear that overrides same-cycle push/pop.
module fetch_queue
    import armv8_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [INSTR_W-1:0] push_data,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic               pop,
    input  logic               clear,
    output logic               full,
    output logic               empty,
    output logic [LW-1:0]      level,
    output logic [INSTR_W-1:0] head_data,
    output logic [ADDR_W-1:0]  head_pc
);

    fetch_entry_t    slots [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head reads as zero while empty so idle outputs are deterministic.
    assign head_data = empty ? '0 : slots[rd_ptr].instr;
    assign head_pc   = empty ? '0 : slots[rd_ptr].pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= '{instr: push_data, pc: push_pc};
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: pc/request FSM feeding fetch_queue, with branch redirect.
// Optional FETCH_STALL_COUNT_EN adds a saturating stall_cnt output.
module fetch_unit
    import armv8_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 64'h0,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [ADDR_W-1:0]  inst_pc
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    localparam int LW = $clog2(QUEUE_DEPTH + 1);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] target;
    logic [LW-1:0]     level;
    logic [LW-1:0]     level_next;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              clear;

    assign target     = redirect_pc & ~64'h3;
    assign push       = (state == REQ) && mem_req && mem_ack && !redirect_valid && !full;
    assign pop        = inst_valid && inst_ready;
    assign clear      = redirect_valid && (state != IDLE);
    assign pc_next    = push ? pc + PC_INC : pc;
    assign level_next = level + LW'(push) - LW'(pop);
    assign inst_valid = !empty;

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (mem_rdata),
        .push_pc   (pc),
        .pop       (pop),
        .clear     (clear),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .head_data (inst_data),
        .head_pc   (inst_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_VECTOR;
            mem_req  <= 1'b0;
            mem_addr <= RESET_VECTOR;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    mem_req  <= 1'b1;
                    pc       <= redirect_valid ? target : pc;
                    mem_addr <= redirect_valid ? target : pc;
                end
                REQ: begin
                    if (redirect_valid) begin
                        pc <= target;
                        // An in-flight request cannot be withdrawn: ride it out in FLUSH.
                        if (mem_req && !mem_ack) begin
                            state <= FLUSH;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= target;
                        end
                    end else begin
                        pc       <= pc_next;
                        mem_req  <= (level_next != LW'(QUEUE_DEPTH));
                        mem_addr <= pc_next;
                    end
                end
                FLUSH: begin
                    if (redirect_valid) pc <= target;
                    if (mem_ack) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= redirect_valid ? target : pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (mem_req && !mem_ack && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, corner sequences and a
// randomized run against a queue-based behavioural model.
module tb_fetch_unit;

    localparam logic [63:0] RV2 = 64'hFFFF_FFFF_FFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, redirect_valid, mem_ack, inst_ready, mem_req, inst_valid;
    logic [63:0] redirect_pc, mem_addr, inst_pc;
    logic [31:0] mem_rdata, inst_data;

    logic        rst2_n, redirect_valid2, mem_ack2, inst_ready2, mem_req2, inst_valid2;
    logic [63:0] redirect_pc2, mem_addr2, inst_pc2;
    logic [31:0] mem_rdata2, inst_data2;
`ifdef FETCH_STALL_COUNT_EN
    logic [31:0] stall_cnt, stall_cnt2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit dut (
`ifdef FETCH_STALL_COUNT_EN
        .stall_cnt(stall_cnt),
`endif
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
    );

    fetch_unit #(.RESET_VECTOR(RV2), .QUEUE_DEPTH(4)) dut2 (
`ifdef FETCH_STALL_COUNT_EN
        .stall_cnt(stall_cnt2),
`endif
        .clk(clk), .rst_n(rst2_n), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2), .mem_rdata(mem_rdata2),
        .inst_valid(inst_valid2), .inst_ready(inst_ready2), .inst_data(inst_data2), .inst_pc(inst_pc2)
    );

    // Behavioural model: a plain queue plus "requesting" / "draining stale request" flags.
    typedef struct { logic [31:0] data; logic [63:0] pc; } ent_t;
    ent_t        m_q[$];
    bit          m_run, m_req, m_flush;
    logic [63:0] m_pc, m_addr;

    function automatic void model_reset();
        m_q.delete();
        m_run = 0; m_req = 0; m_flush = 0; m_pc = 64'h0; m_addr = 64'h0;
    endfunction

    function automatic void model_step(bit redir, logic [63:0] rpc, bit ack, logic [31:0] rd, bit rdy);
        logic [63:0] tgt;
        tgt = rpc & ~64'h3;
        if (!m_run) begin
            m_run = 1; m_req = 1; m_addr = m_pc;
        end else if (m_flush) begin
            if (redir) m_pc = tgt;
            if (ack) begin m_flush = 0; m_req = 1; m_addr = m_pc; end
        end else if (redir) begin
            m_q.delete();
            m_pc = tgt;
            if (m_req && !ack) m_flush = 1;
            else begin m_req = 1; m_addr = tgt; end
        end else begin
            if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
            if (m_req && ack) begin
                m_q.push_back('{rd, m_pc});
                m_pc = m_pc + 64'd4;
            end
            m_req  = (m_q.size() < 2);
            m_addr = m_pc;
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input bit e_req, input logic [63:0] e_addr,
                           input bit e_valid, input logic [63:0] e_pc, input logic [31:0] e_data);
        chk({tag, ".mem_req"}, {63'h0, mem_req}, {63'h0, e_req});
        chk({tag, ".mem_addr"}, mem_addr, e_addr);
        chk({tag, ".inst_valid"}, {63'h0, inst_valid}, {63'h0, e_valid});
        if (e_valid) begin
            chk({tag, ".inst_pc"}, inst_pc, e_pc);
            chk({tag, ".inst_data"}, {32'h0, inst_data}, {32'h0, e_data});
        end
    endtask

    task automatic drive(input bit redir, input logic [63:0] rpc, input bit ack,
                         input logic [31:0] rd, input bit rdy);
        redirect_valid = redir; redirect_pc = rpc; mem_ack = ack; mem_rdata = rd; inst_ready = rdy;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 0; redirect_valid = 0; redirect_pc = 0; mem_ack = 0; mem_rdata = 0; inst_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.mem_req", {63'h0, mem_req}, 64'h0);
        chk("rst.mem_addr", mem_addr, 64'h0);
        chk("rst.inst_valid", {63'h0, inst_valid}, 64'h0);
        chk("rst.inst_data", {32'h0, inst_data}, 64'h0);
        chk("rst.inst_pc", inst_pc, 64'h0);
        rst_n = 1;
    endtask

    typedef struct {
        bit redir; logic [63:0] rpc; bit ack; logic [31:0] rd; bit rdy;
        bit e_req; logic [63:0] e_addr; bit e_valid; logic [63:0] e_pc; logic [31:0] e_data;
    } vec_t;
    vec_t vecs[18];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    initial begin
        //          redir rpc      ack rdata         rdy  req addr    vld pc       data
        vecs[0]  = '{0, 64'h0,    1, 32'hDEADBEEF, 1,  1, 64'h0,    0, 64'h0,    32'h0};
        vecs[1]  = '{0, 64'h0,    1, 32'hA0A0A0A0, 1,  1, 64'h4,    1, 64'h0,    32'hA0A0A0A0};
        vecs[2]  = '{0, 64'h0,    1, 32'hA1A1A1A1, 1,  1, 64'h8,    1, 64'h4,    32'hA1A1A1A1};
        vecs[3]  = '{0, 64'h0,    1, 32'hA2A2A2A2, 1,  1, 64'hC,    1, 64'h8,    32'hA2A2A2A2};
        vecs[4]  = '{0, 64'h0,    0, 32'h0,        0,  1, 64'hC,    1, 64'h8,    32'hA2A2A2A2};
        vecs[5]  = '{0, 64'h0,    1, 32'hA3A3A3A3, 0,  0, 64'h10,   1, 64'h8,    32'hA2A2A2A2};
        vecs[6]  = '{0, 64'h0,    1, 32'hBADBAD00, 0,  0, 64'h10,   1, 64'h8,    32'hA2A2A2A2};
        vecs[7]  = '{0, 64'h0,    0, 32'h0,        1,  1, 64'h10,   1, 64'hC,    32'hA3A3A3A3};
        vecs[8]  = '{0, 64'h0,    0, 32'h0,        0,  1, 64'h10,   1, 64'hC,    32'hA3A3A3A3};
        vecs[9]  = '{1, 64'h40,   0, 32'h0,        1,  1, 64'h10,   0, 64'h0,    32'h0};
        vecs[10] = '{1, 64'h203,  0, 32'h0,        1,  1, 64'h10,   0, 64'h0,    32'h0};
        vecs[11] = '{0, 64'h0,    1, 32'hBADBAD01, 1,  1, 64'h200,  0, 64'h0,    32'h0};
        vecs[12] = '{0, 64'h0,    1, 32'hB0B0B0B0, 1,  1, 64'h204,  1, 64'h200,  32'hB0B0B0B0};
        vecs[13] = '{1, 64'h1000, 1, 32'hBADBAD02, 1,  1, 64'h1000, 0, 64'h0,    32'h0};
        vecs[14] = '{0, 64'h0,    1, 32'hC0C0C0C0, 0,  1, 64'h1004, 1, 64'h1000, 32'hC0C0C0C0};
        vecs[15] = '{0, 64'h0,    0, 32'h0,        0,  1, 64'h1004, 1, 64'h1000, 32'hC0C0C0C0};
        vecs[16] = '{0, 64'h0,    1, 32'hC1C1C1C1, 0,  0, 64'h1008, 1, 64'h1000, 32'hC0C0C0C0};
        vecs[17] = '{1, 64'h2003, 0, 32'h0,        0,  1, 64'h2000, 0, 64'h0,    32'h0};

        rst2_n = 0; redirect_valid2 = 0; redirect_pc2 = 0; mem_ack2 = 0; mem_rdata2 = 0; inst_ready2 = 0;

        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].redir, vecs[i].rpc, vecs[i].ack, vecs[i].rd, vecs[i].rdy);
            chk_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                    vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_data);
        end

        // Asynchronous reset in the middle of a pending request.
        redirect_valid = 0; mem_ack = 0; inst_ready = 0;
        rst_n = 0;
        #1;
        chk("midrst.mem_req", {63'h0, mem_req}, 64'h0);
        chk("midrst.mem_addr", mem_addr, 64'h0);
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        model_step(0, 64'h0, 0, 32'h0, 0);
        drive(0, 64'h0, 0, 32'h0, 0);
        chk_out("postrst", 1, 64'h0, 0, 64'h0, 32'h0);

        // Randomized run against the model.
        for (int i = 0; i < 1000; i++) begin
            bit          r, a, y;
            logic [63:0] rp;
            logic [31:0] rd;
            r  = m_run && ($urandom_range(0, 15) == 0);
            a  = ($urandom_range(0, 1) == 1);
            y  = ($urandom_range(0, 4) < 3);
            rp = {$urandom, $urandom};
            rd = $urandom;
            model_step(r, rp, a, rd, y);
            drive(r, rp, a, rd, y);
            chk_out("rand", m_req, m_addr, m_q.size() > 0,
                    (m_q.size() > 0) ? m_q[0].pc : 64'h0,
                    (m_q.size() > 0) ? m_q[0].data : 32'h0);
        end

        // Wrapping reset vector and a four-entry queue on the second instance.
        chk("d2rst.mem_addr", mem_addr2, RV2);
        chk("d2rst.mem_req", {63'h0, mem_req2}, 64'h0);
        rst2_n = 1; mem_ack2 = 1; mem_rdata2 = 32'h5555AAAA; inst_ready2 = 0;
        @(posedge clk); #1;
        chk("d2.e1.mem_req", {63'h0, mem_req2}, 64'h1);
        chk("d2.e1.mem_addr", mem_addr2, RV2);
        @(posedge clk); #1;
        chk("d2.wrap.mem_addr", mem_addr2, 64'h0);
        chk("d2.wrap.inst_valid", {63'h0, inst_valid2}, 64'h1);
        chk("d2.wrap.inst_pc", inst_pc2, RV2);
        chk("d2.wrap.inst_data", {32'h0, inst_data2}, 64'h5555AAAA);
        @(posedge clk); #1;
        chk("d2.e3.mem_addr", mem_addr2, 64'h4);
        @(posedge clk); #1;
        chk("d2.e4.mem_addr", mem_addr2, 64'h8);
        chk("d2.e4.mem_req", {63'h0, mem_req2}, 64'h1);
        @(posedge clk); #1;
        chk("d2.full.mem_req", {63'h0, mem_req2}, 64'h0);
        chk("d2.full.mem_addr", mem_addr2, 64'hC);
        chk("d2.full.inst_pc", inst_pc2, RV2);
        mem_ack2 = 0;

`ifdef FETCH_STALL_COUNT_EN
        do_reset();
        chk("stall.rst", {32'h0, stall_cnt}, 64'h0);
        drive(0, 64'h0, 0, 32'h0, 1);
        for (int k = 0; k < 2; k++) begin
            drive(0, 64'h0, 0, 32'h0, 1);
            drive(0, 64'h0, 0, 32'h0, 1);
            drive(0, 64'h0, 1, 32'h12345678, 1);
        end
        chk("stall.count", {32'h0, stall_cnt}, 64'h4);
        mem_ack = 0;
        rst_n = 0;
        #1;
        chk("stall.clear", {32'h0, stall_cnt}, 64'h0);
        rst_n = 1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
